// File: rtl/arb_grant_server.sv
// Grant server for the 4-way round-robin arbiter: latches the winner, moves a fixed burst
// onto the shared bus, then acks the arbiter. Optional grant check: `ARB_GRANT_CHECK_EN`.
module arb_grant_server #(
  parameter int unsigned DW      = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    grant,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic          bus_ready,
  output logic [DW-1:0] bus_data,
  output logic          bus_valid,
  output logic          ack,
  output logic [3:0]    done,
  output logic          busy,
  output logic          err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  // One counter serves both the beat count (XFER) and the holdoff count (HOLD).
  localparam logic [3:0] BurstM1   = 4'(BURST - 1);
  localparam logic [3:0] HoldoffM1 = 4'(HOLDOFF - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic [3:0]    grant_sel;
  logic [DW-1:0] mux_data;

`ifdef ARB_GRANT_CHECK_EN
  logic grant_onehot;
  logic err_q;

  assign grant_onehot = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
  assign accept       = grant_onehot;
  assign grant_sel    = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && grant != 4'd0 && !grant_onehot) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Unchecked build: lowest set bit wins.
  assign accept    = (grant != 4'd0);
  assign grant_sel = grant & (~grant + 4'd1);
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d   = grant_sel;
          cnt_d   = BurstM1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (bus_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = StAck;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StAck: begin
        cnt_d   = HoldoffM1;
        state_d = StHold;
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          sel_d   = 4'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mux_data = '0;
    unique case (sel_q)
      4'b0001: mux_data = din0;
      4'b0010: mux_data = din1;
      4'b0100: mux_data = din2;
      4'b1000: mux_data = din3;
      default: mux_data = '0;
    endcase
  end

  assign bus_valid = (state_q == StXfer);
  assign bus_data  = bus_valid ? mux_data : '0;
  assign ack       = (state_q == StAck);
  assign done      = ack ? sel_q : 4'd0;
  assign busy      = (state_q != StIdle);

endmodule
